// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I decode definitions.
//   - base-ISA opcode constants
//   - immediate format selector and the opcode -> format mapping
//   - per-opcode source/destination usage helpers
//   - decoded control fields carried in the execute bundle
package rv32_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,  // R-type: no immediate
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Decoded control fields registered alongside the operands.
  typedef struct packed {
    logic [4:0] rd;
    logic       rd_we;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       illegal;
  } dec_ctl_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    case (opc)
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: imm_fmt = IMM_I;
      STORE:                                imm_fmt = IMM_S;
      BRANCH:                               imm_fmt = IMM_B;
      LUI, AUIPC:                           imm_fmt = IMM_U;
      JAL:                                  imm_fmt = IMM_J;
      default:                              imm_fmt = IMM_NONE;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
      LUI, AUIPC, SYSTEM, MISC_MEM: is_legal = 1'b1;
      default:                      is_legal = 1'b0;
    endcase
  endfunction

  // rs1 is read by everything except the pc/upper-immediate forms.
  function automatic logic uses_rs1(input logic [6:0] opc);
    uses_rs1 = !(opc == LUI || opc == AUIPC || opc == JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    uses_rs2 = (opc == OP || opc == STORE || opc == BRANCH);
  endfunction

  // Opcode class writes rd; x0 and illegal filtering happen in the stage.
  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC, SYSTEM: writes_rd = 1'b1;
      default:                                         writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen: combinational immediate extraction.
//   instr  in   32    instruction word (opcode taken from instr[6:0])
//   imm    out  XLEN  sign-extended immediate, 0 for formats without one
module rv32_imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_fmt(instr[6:0]))
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed size cast sign-extends when XLEN is wider than 32.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: RV32I decode / register-read stage.
//   clk, rst_n          clock, async active-low reset
//   flush               kill held bundle and all pending-write state
//   if_valid/if_ready   fetch handshake; if_instr, if_pc payload
//   rf_addr_a/b         register file read addresses (rs1/rs2 fields)
//   rf_data_a/b         combinational register file read data
//   ex_valid/ex_ready   execute handshake; ex_* registered decoded bundle
//   wb_valid, wb_rd     writeback retire, clears the pending-write bit
// A scoreboard of in-flight rd writes stalls fetch on read-after-write hazards.
// There is no bypass: a consumer waits until the cycle after its producer's
// writeback, when the register file already holds the new value.
module rv32_decode_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [AW-1:0]   rf_addr_a,
  output logic [AW-1:0]   rf_addr_b,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_rd_we,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_illegal,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd
);

  localparam int NREG = 1 << AW;

  logic [6:0]      opcode;
  logic [AW-1:0]   rs1, rs2, rd;
  logic            legal, rs1_used, rs2_used, rd_we;
  logic            hazard, accept;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [NREG-1:0] busy, busy_rd, busy_nxt;

  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  dec_ctl_t        ctl_q;

  // ---------------- decode ----------------
  assign opcode   = if_instr[6:0];
  assign rs1      = if_instr[15 +: AW];
  assign rs2      = if_instr[20 +: AW];
  assign rd       = if_instr[7 +: AW];
  assign legal    = is_legal(opcode);
  assign rs1_used = uses_rs1(opcode);
  assign rs2_used = uses_rs2(opcode);
  assign rd_we    = legal && writes_rd(opcode) && (rd != '0);

  assign rf_addr_a = rs1;
  assign rf_addr_b = rs2;

  // x0 reads as zero regardless of what the register file returns.
  assign rs1_val = (rs1 == '0) ? '0 : rf_data_a;
  assign rs2_val = (rs2 == '0) ? '0 : rf_data_b;

  rv32_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (imm)
  );

  // ---------------- hazard / handshake ----------------
  assign busy_rd = {busy[NREG-1:1], 1'b0};
  assign hazard  = (rs1_used && busy_rd[rs1]) || (rs2_used && busy_rd[rs2]);
  assign if_ready = !flush && !hazard && (!ex_valid || ex_ready);
  assign accept   = if_valid && if_ready;

  // Clear on retire first, then set on issue, so a same-edge issue of the
  // same rd keeps the bit (the new writer is still outstanding).
  always_comb begin
    busy_nxt = busy;
    if (wb_valid)
      busy_nxt[wb_rd] = 1'b0;
    if (accept && rd_we)
      busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    if (flush)
      busy_nxt = '0;
  end

  // ---------------- pipeline register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      busy     <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      ctl_q    <= '0;
    end else begin
      busy <= busy_nxt;
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid       <= 1'b1;
        pc_q           <= if_pc;
        rs1_q          <= rs1_val;
        rs2_q          <= rs2_val;
        imm_q          <= imm;
        ctl_q.rd       <= if_instr[11:7];
        ctl_q.rd_we    <= rd_we;
        ctl_q.opcode   <= opcode;
        ctl_q.funct3   <= if_instr[14:12];
        ctl_q.funct7b5 <= if_instr[30];
        ctl_q.illegal  <= !legal;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

  assign ex_pc       = pc_q;
  assign ex_rs1_val  = rs1_q;
  assign ex_rs2_val  = rs2_q;
  assign ex_imm      = imm_q;
  assign ex_rd       = ctl_q.rd[AW-1:0];
  assign ex_rd_we    = ctl_q.rd_we;
  assign ex_opcode   = ctl_q.opcode;
  assign ex_funct3   = ctl_q.funct3;
  assign ex_funct7b5 = ctl_q.funct7b5;
  assign ex_illegal  = ctl_q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  // Register file model: combinational read, write on the clock edge.
  assign rf_data_a = rf_mem[rf_addr_a];
  assign rf_data_b = rf_mem[rf_addr_b];
  always @(posedge clk)
    if (wb_valid && wb_rd != 5'd0) rf_mem[wb_rd] <= wb_data;

  rv32_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_illegal(ex_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1; if_instr = instr; if_pc = pc;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA5A5_0000 | i;
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid); end
    checks++; if ({ex_pc, ex_imm, ex_rs1_val} !== 96'd0) begin errors++; $display("FAIL reset_data got %h want 0", {ex_pc, ex_imm, ex_rs1_val}); end
    checks++; if ({ex_rd, ex_rd_we, ex_opcode, ex_illegal} !== 14'd0) begin errors++; $display("FAIL reset_ctl got %h want 0", {ex_rd, ex_rd_we, ex_opcode, ex_illegal}); end
    rst_n = 1'b1; #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %0b want 1", if_ready); end
  endtask

  task automatic test_addi();
    present(32'h0050_0093, 32'h0);   // addi x1,x0,5
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd1 || ex_imm !== 32'd5 || ex_rd_we !== 1'b1)
      begin errors++; $display("FAIL addi_bundle got v=%0b rd=%0d imm=%h we=%0b want v=1 rd=1 imm=5 we=1", ex_valid, ex_rd, ex_imm, ex_rd_we); end
    checks++; if (ex_opcode !== 7'h13 || ex_rs1_val !== 32'd0 || ex_pc !== 32'd0)
      begin errors++; $display("FAIL addi_fields got op=%h rs1=%h pc=%h want op=13 rs1=0 pc=0", ex_opcode, ex_rs1_val, ex_pc); end
  endtask

  task automatic test_raw_hazard();
    present(32'h0010_8133, 32'h4);   // add x2,x1,x1
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL raw_stall0 got %0b want 0", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0 || if_ready !== 1'b0)
      begin errors++; $display("FAIL raw_stall1 got v=%0b rdy=%0b want v=0 rdy=0", ex_valid, if_ready); end
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle got %0b want 0", if_ready); end
    tick();
    wb_valid = 1'b0; #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %0b want 1", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rs1_val !== 32'd5 || ex_rs2_val !== 32'd5 || ex_rd !== 5'd2 || ex_imm !== 32'd0)
      begin errors++; $display("FAIL raw_issue got v=%0b a=%h b=%h rd=%0d imm=%h want v=1 a=5 b=5 rd=2 imm=0", ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm); end
    if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    present(32'h0070_0313, 32'h40);  // addi x6,x0,7
    tick();
    present(32'h0090_0393, 32'h44);  // addi x7,x0,9
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if_ready !== 1'b0 || ex_valid !== 1'b1 || ex_pc !== 32'h40 || ex_rd !== 5'd6 || ex_imm !== 32'd7)
        begin errors++; $display("FAIL hold_%0d got rdy=%0b v=%0b pc=%h rd=%0d imm=%h want rdy=0 v=1 pc=40 rd=6 imm=7", i, if_ready, ex_valid, ex_pc, ex_rd, ex_imm); end
      tick();
    end
    ex_ready = 1'b1; #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %0b want 1", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h44 || ex_rd !== 5'd7 || ex_imm !== 32'd9)
      begin errors++; $display("FAIL hold_next got v=%0b pc=%h rd=%0d imm=%h want v=1 pc=44 rd=7 imm=9", ex_valid, ex_pc, ex_rd, ex_imm); end
    if_valid = 1'b0;
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL drain got %0b want 0", ex_valid); end
  endtask

  task automatic test_x0();
    present(32'h0010_0013, 32'h80);  // addi x0,x0,1
    tick();
    checks++; if (ex_rd_we !== 1'b0 || ex_rd !== 5'd0 || ex_rs1_val !== 32'd0)
      begin errors++; $display("FAIL x0_addi got we=%0b rd=%0d a=%h want we=0 rd=0 a=0", ex_rd_we, ex_rd, ex_rs1_val); end
    present(32'h0000_01B3, 32'h84);  // add x3,x0,x0
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL x0_no_stall got %0b want 1", if_ready); end
    tick();
    checks++; if (ex_rd_we !== 1'b1 || ex_rd !== 5'd3 || ex_rs1_val !== 32'd0 || ex_rs2_val !== 32'd0)
      begin errors++; $display("FAIL x0_add got we=%0b rd=%0d a=%h b=%h want we=1 rd=3 a=0 b=0", ex_rd_we, ex_rd, ex_rs1_val, ex_rs2_val); end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_set_wins();
    present(32'h0010_0213, 32'hC0);  // addi x4,x0,1
    tick();
    present(32'h0020_0213, 32'hC4);  // addi x4,x0,2 issued as older x4 retires
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44; #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL waw_ready got %0b want 1", if_ready); end
    tick();
    wb_valid = 1'b0;
    checks++; if (ex_imm !== 32'd2) begin errors++; $display("FAIL waw_imm got %h want 2", ex_imm); end
    present(32'h0002_0433, 32'hC8);  // add x8,x4,x0
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL setwins_stall0 got %0b want 0", if_ready); end
    tick();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL setwins_stall1 got %0b want 0", if_ready); end
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h88;
    tick();
    wb_valid = 1'b0; #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL setwins_release got %0b want 1", if_ready); end
    tick();
    checks++; if (ex_rs1_val !== 32'h88 || ex_rs2_val !== 32'd0 || ex_rd !== 5'd8)
      begin errors++; $display("FAIL setwins_issue got a=%h b=%h rd=%0d want a=88 b=0 rd=8", ex_rs1_val, ex_rs2_val, ex_rd); end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_illegal();
    ex_ready = 1'b0;
    present(32'h0030_0293, 32'h100); // addi x5,x0,3
    tick();
    flush = 1'b1;
    present(32'h0010_0493, 32'h104); // addi x9,x0,1 (must not be taken)
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b want 0", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", ex_valid); end
    flush = 1'b0; ex_ready = 1'b1;
    present(32'h0052_8533, 32'h108); // add x10,x5,x5
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_sb_clear got %0b want 1", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || ex_rs1_val !== 32'hA5A5_0005 || ex_pc !== 32'h108)
      begin errors++; $display("FAIL flush_next got v=%0b rd=%0d a=%h pc=%h want v=1 rd=10 a=a5a50005 pc=108", ex_valid, ex_rd, ex_rs1_val, ex_pc); end
    present(32'h0000_05FF, 32'h10C); // opcode 0x7f, rd=x11
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_rd_we !== 1'b0 || ex_rd !== 5'd11)
      begin errors++; $display("FAIL illegal got v=%0b ill=%0b we=%0b rd=%0d want v=1 ill=1 we=0 rd=11", ex_valid, ex_illegal, ex_rd_we, ex_rd); end
    present(32'h00B5_8633, 32'h110); // add x12,x11,x11
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL illegal_no_busy got %0b want 1", if_ready); end
    tick();
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_imm_formats();
    logic [31:0] instrs [4];
    logic [31:0] imms   [4];
    instrs[0] = 32'h1234_56B7; imms[0] = 32'h1234_5000;  // lui x13
    instrs[1] = 32'hFE50_2E23; imms[1] = 32'hFFFF_FFFC;  // sw x5,-4(x0)
    instrs[2] = 32'hFE00_0CE3; imms[2] = 32'hFFFF_FFF8;  // beq x0,x0,-8
    instrs[3] = 32'h0010_00EF; imms[3] = 32'h0000_0800;  // jal x1,+2048
    for (int i = 0; i < 4; i++) begin
      present(instrs[i], 32'h200 + 32'(i * 4));
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_imm !== imms[i] || ex_illegal !== 1'b0)
        begin errors++; $display("FAIL imm_fmt_%0d got v=%0b imm=%h ill=%0b want v=1 imm=%h ill=0", i, ex_valid, ex_imm, ex_illegal, imms[i]); end
    end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    ex_ready = 1'b0;
    present(32'h0070_0313, 32'h300);
    tick();
    if_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0)
      begin errors++; $display("FAIL async_reset got v=%0b pc=%h want v=0 pc=0", ex_valid, ex_pc); end
    tick();
    rst_n = 1'b1; ex_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw_hazard();
    test_backpressure();
    test_x0();
    test_set_wins();
    test_flush_illegal();
    test_imm_formats();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
